// File: rtl/fp_alu_sequencer.sv
// fp_alu_sequencer: issues micro-instructions to the fixed-point ALU or the external isqrt unit and writes results back.
// Define FP_SEQ_PERF_CNT_EN to enable instr_count_out/stall_count_out; otherwise they are tied to 0.
`ifndef WIDTH
`define WIDTH 32
`endif
module fp_alu_sequencer #(
  parameter int NREGS = 8,
  localparam int RA = $clog2(NREGS)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              instr_valid_in,
  output logic              instr_ready_out,
  input  logic [2:0]        instr_op_in,
  input  logic [RA-1:0]     instr_dst_in,
  input  logic [RA-1:0]     instr_src0_in,
  input  logic [RA-1:0]     instr_src1_in,
  input  logic              wr_en_in,
  input  logic [RA-1:0]     wr_addr_in,
  input  logic [`WIDTH-1:0] wr_data_in,
  input  logic [RA-1:0]     rd_addr_in,
  output logic [`WIDTH-1:0] rd_data_out,
  output logic [`WIDTH-1:0] alu_d1_out,
  output logic [`WIDTH-1:0] alu_d0_out,
  output logic [2:0]        alu_sel_out,
  input  logic [`WIDTH-1:0] alu_res_in,
  input  logic              alu_gt_in,
  input  logic              alu_eq_in,
  input  logic              alu_lt_in,
  output logic              isqrt_valid_out,
  input  logic              isqrt_ready_in,
  output logic [`WIDTH-1:0] isqrt_d_out,
  input  logic              isqrt_res_valid_in,
  input  logic [`WIDTH-1:0] isqrt_res_in,
  output logic              done_out,
  output logic [`WIDTH-1:0] result_out,
  output logic              gt_out,
  output logic              eq_out,
  output logic              lt_out,
  output logic [31:0]       instr_count_out,
  output logic [31:0]       stall_count_out
);
  typedef enum logic [1:0] {IDLE, EXEC, ISQ_REQ, ISQ_WAIT} state_t;
  state_t state;
  logic [`WIDTH-1:0] regs [NREGS];
  logic [RA-1:0] dst;
  logic [`WIDTH-1:0] wb;
  assign rd_data_out = regs[rd_addr_in];
  // operand A stays latched on alu_d1_out, which also feeds the isqrt unit
  assign isqrt_d_out = alu_d1_out;
  assign wb = alu_sel_out == 3'b111 ? '0 : alu_res_in;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      instr_ready_out <= 1'b0;
      dst <= '0;
      alu_d1_out <= '0;
      alu_d0_out <= '0;
      alu_sel_out <= '0;
      isqrt_valid_out <= 1'b0;
      done_out <= 1'b0;
      result_out <= '0;
      {gt_out, eq_out, lt_out} <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done_out <= 1'b0;
      // host write first so a same-cycle writeback to the same address overrides it
      if (wr_en_in) regs[wr_addr_in] <= wr_data_in;
      case (state)
        IDLE: begin
          instr_ready_out <= 1'b1;
          if (instr_valid_in && instr_ready_out) begin
            instr_ready_out <= 1'b0;
            dst <= instr_dst_in;
            alu_d1_out <= regs[instr_src0_in];
            alu_d0_out <= regs[instr_src1_in];
            if (instr_op_in == 3'b010) begin
              state <= ISQ_REQ;
              isqrt_valid_out <= 1'b1;
            end else begin
              state <= EXEC;
              alu_sel_out <= instr_op_in;
            end
          end
        end
        EXEC: begin
          regs[dst] <= wb;
          result_out <= wb;
          {gt_out, eq_out, lt_out} <= {alu_gt_in, alu_eq_in, alu_lt_in};
          alu_sel_out <= '0;
          done_out <= 1'b1;
          instr_ready_out <= 1'b1;
          state <= IDLE;
        end
        ISQ_REQ: begin
          if (isqrt_ready_in) begin
            isqrt_valid_out <= 1'b0;
            state <= ISQ_WAIT;
          end
        end
        ISQ_WAIT: begin
          if (isqrt_res_valid_in) begin
            regs[dst] <= isqrt_res_in;
            result_out <= isqrt_res_in;
            done_out <= 1'b1;
            instr_ready_out <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef FP_SEQ_PERF_CNT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      instr_count_out <= '0;
      stall_count_out <= '0;
    end else begin
      if (done_out && !(&instr_count_out)) instr_count_out <= instr_count_out + 32'd1;
      if ((state == ISQ_REQ || state == ISQ_WAIT) && !(&stall_count_out)) stall_count_out <= stall_count_out + 32'd1;
    end
  end
`else
  assign instr_count_out = '0;
  assign stall_count_out = '0;
`endif
endmodule

// File: tb/tb_fp_alu_sequencer.sv
// tb_fp_alu_sequencer: directed and randomized checks of fp_alu_sequencer against a register-file model.
`ifndef WIDTH
`define WIDTH 32
`endif
module tb_fp_alu_sequencer;
  localparam int W = `WIDTH;
  localparam int N = 8;
  localparam int FRAC = W / 2;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic instr_valid_in = 1'b0;
  logic instr_ready_out;
  logic [2:0] instr_op_in = '0;
  logic [2:0] instr_dst_in = '0, instr_src0_in = '0, instr_src1_in = '0;
  logic wr_en_in = 1'b0;
  logic [2:0] wr_addr_in = '0;
  logic [W-1:0] wr_data_in = '0;
  logic [2:0] rd_addr_in = '0;
  logic [W-1:0] rd_data_out;
  logic [W-1:0] alu_d1_out, alu_d0_out, alu_res_in;
  logic [2:0] alu_sel_out;
  logic alu_gt_in, alu_eq_in, alu_lt_in;
  logic isqrt_valid_out;
  logic isqrt_ready_in = 1'b0;
  logic [W-1:0] isqrt_d_out;
  logic isqrt_res_valid_in = 1'b0;
  logic [W-1:0] isqrt_res_in = '0;
  logic done_out;
  logic [W-1:0] result_out;
  logic gt_out, eq_out, lt_out;
  logic [31:0] instr_count_out, stall_count_out;

  fp_alu_sequencer #(.NREGS(N)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
    .instr_op_in(instr_op_in), .instr_dst_in(instr_dst_in),
    .instr_src0_in(instr_src0_in), .instr_src1_in(instr_src1_in),
    .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .rd_addr_in(rd_addr_in), .rd_data_out(rd_data_out),
    .alu_d1_out(alu_d1_out), .alu_d0_out(alu_d0_out), .alu_sel_out(alu_sel_out),
    .alu_res_in(alu_res_in), .alu_gt_in(alu_gt_in), .alu_eq_in(alu_eq_in), .alu_lt_in(alu_lt_in),
    .isqrt_valid_out(isqrt_valid_out), .isqrt_ready_in(isqrt_ready_in), .isqrt_d_out(isqrt_d_out),
    .isqrt_res_valid_in(isqrt_res_valid_in), .isqrt_res_in(isqrt_res_in),
    .done_out(done_out), .result_out(result_out),
    .gt_out(gt_out), .eq_out(eq_out), .lt_out(lt_out),
    .instr_count_out(instr_count_out), .stall_count_out(stall_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural fixed-point ALU: Q(W/2).(W/2) signed arithmetic on plain integers.
  function automatic logic [W-1:0] alu_calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    case (op)
      3'b000: return W'(sa + sb);
      3'b001: return W'((sa * sb) >>> FRAC);
      3'b011: return sa > sb ? a : b;
      3'b100: return W'(sa - sb);
      3'b101: return sa < 0 ? W'(-(longint'(1) << FRAC)) : sa > 0 ? W'(longint'(1) << FRAC) : '0;
      3'b110: return sa < sb ? a : b;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_res_in = alu_calc(alu_sel_out, alu_d1_out, alu_d0_out);
    alu_gt_in = $signed(alu_d1_out) > $signed(alu_d0_out);
    alu_eq_in = alu_d1_out == alu_d0_out;
    alu_lt_in = $signed(alu_d1_out) < $signed(alu_d0_out);
  end

  logic [W-1:0] m [N];
  logic mgt = 1'b0, meq = 1'b0, mlt = 1'b0;
  int n_vec = 0, n_err = 0, n_done = 0, stall_exp = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [W-1:0] d);
    wr_en_in = 1'b1;
    wr_addr_in = a;
    wr_data_in = d;
    tick;
    wr_en_in = 1'b0;
    m[a] = d;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a);
    rd_addr_in = a;
    #1;
    chk(tag, rd_data_out, m[a]);
  endtask

  task automatic wait_ready;
    int t = 0;
    while (instr_ready_out !== 1'b1 && t < 20) begin
      tick;
      t++;
    end
    chk("ready_wait", instr_ready_out, 1);
  endtask

  task automatic exec_op(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s0, input logic [2:0] s1,
                         input bit hwa_en, input logic [2:0] hwa_addr, input bit hwb_en, input logic [2:0] hwb_addr,
                         input logic [W-1:0] hwd);
    logic [W-1:0] a, b, r;
    wait_ready;
    a = m[s0];
    b = m[s1];
    instr_op_in = op;
    instr_dst_in = d;
    instr_src0_in = s0;
    instr_src1_in = s1;
    instr_valid_in = 1'b1;
    wr_en_in = hwa_en;
    wr_addr_in = hwa_addr;
    wr_data_in = hwd;
    tick;
    instr_valid_in = 1'b0;
    if (hwa_en) m[hwa_addr] = hwd;
    wr_en_in = hwb_en;
    wr_addr_in = hwb_addr;
    wr_data_in = ~hwd;
    chk("exec_sel", alu_sel_out, op);
    chk("exec_d1", alu_d1_out, a);
    chk("exec_d0", alu_d0_out, b);
    chk("exec_done_early", done_out, 0);
    chk("exec_busy", instr_ready_out, 0);
    tick;
    wr_en_in = 1'b0;
    if (hwb_en) m[hwb_addr] = ~hwd;
    r = op == 3'b111 ? '0 : alu_calc(op, a, b);
    m[d] = r;
    mgt = $signed(a) > $signed(b);
    meq = a == b;
    mlt = $signed(a) < $signed(b);
    n_done++;
    chk("wb_done", done_out, 1);
    chk("wb_result", result_out, r);
    chk("wb_flags", {gt_out, eq_out, lt_out}, {mgt, meq, mlt});
    chk("wb_sel_idle", alu_sel_out, 0);
    check_reg("wb_reg", d);
    if (hwb_en) check_reg("wb_host_reg", hwb_addr);
  endtask

  task automatic isqrt_op(input logic [2:0] d, input logic [2:0] s0, input int rdy_dly, input int rsp_dly,
                          input logic [W-1:0] rsp);
    logic [W-1:0] a;
    wait_ready;
    a = m[s0];
    instr_op_in = 3'b010;
    instr_dst_in = d;
    instr_src0_in = s0;
    instr_src1_in = 3'(~s0);
    instr_valid_in = 1'b1;
    tick;
    instr_valid_in = 1'b0;
    chk("isq_sel", alu_sel_out, 0);
    for (int i = 0; i < rdy_dly; i++) begin
      chk("isq_valid", isqrt_valid_out, 1);
      chk("isq_d", isqrt_d_out, a);
      chk("isq_busy", instr_ready_out, 0);
      isqrt_res_valid_in = i == 0;
      isqrt_res_in = ~rsp;
      tick;
      stall_exp++;
    end
    isqrt_res_valid_in = 1'b0;
    chk("isq_valid_hs", isqrt_valid_out, 1);
    chk("isq_d_hs", isqrt_d_out, a);
    isqrt_ready_in = 1'b1;
    tick;
    stall_exp++;
    isqrt_ready_in = 1'b0;
    chk("isq_drop", isqrt_valid_out, 0);
    for (int i = 0; i < rsp_dly; i++) begin
      chk("isq_wait_done", done_out, 0);
      chk("isq_wait_busy", instr_ready_out, 0);
      tick;
      stall_exp++;
    end
    isqrt_res_valid_in = 1'b1;
    isqrt_res_in = rsp;
    tick;
    stall_exp++;
    isqrt_res_valid_in = 1'b0;
    m[d] = rsp;
    n_done++;
    chk("isq_done", done_out, 1);
    chk("isq_result", result_out, rsp);
    chk("isq_flags", {gt_out, eq_out, lt_out}, {mgt, meq, mlt});
    check_reg("isq_reg", d);
  endtask

  task automatic back_to_back;
    int acc = 0, last = 0, cyc = 0;
    bit take;
    instr_op_in = 3'b000;
    instr_dst_in = 3'd1;
    instr_src0_in = 3'd1;
    instr_src1_in = 3'd1;
    instr_valid_in = 1'b1;
    while (acc < 4 && cyc < 20) begin
      take = instr_ready_out;
      tick;
      cyc++;
      if (take) begin
        if (acc > 0) chk("b2b_gap", cyc - last, 2);
        last = cyc;
        acc++;
        m[1] = m[1] + m[1];
        n_done++;
        if (acc == 4) instr_valid_in = 1'b0;
      end
    end
    instr_valid_in = 1'b0;
    chk("b2b_accepts", acc, 4);
    tick;
    {mgt, meq, mlt} = 3'b010;
    chk("b2b_result", result_out, 32'h0010_0000);
    chk("b2b_eq", eq_out, 1);
    check_reg("b2b_reg", 3'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) m[i] = '0;
    tick;
    tick;
    chk("rst_ready", instr_ready_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_isq_valid", isqrt_valid_out, 0);
    chk("rst_result", result_out, 0);
    chk("rst_sel", alu_sel_out, 0);
    rst_in = 1'b0;
    chk("rel_ready_low", instr_ready_out, 0);
    tick;
    chk("rel_ready_high", instr_ready_out, 1);
    host_write(3'd1, 32'h0001_8000);
    host_write(3'd2, 32'h0002_4000);
    exec_op(3'b000, 3'd3, 3'd1, 3'd2, 0, 3'd0, 0, 3'd0, '0);
    chk("add_3p75", result_out, 32'h0003_C000);
    chk("add_lt", {gt_out, lt_out}, 2'b01);
    host_write(3'd5, 32'hFFFE_0000);
    exec_op(3'b001, 3'd4, 3'd1, 3'd5, 0, 3'd0, 0, 3'd0, '0);
    chk("mul_neg3", result_out, 32'hFFFD_0000);
    exec_op(3'b100, 3'd6, 3'd4, 3'd4, 0, 3'd0, 0, 3'd0, '0);
    chk("sub_zero", result_out, 32'h0);
    chk("sub_eq", eq_out, 1);
    host_write(3'd7, 32'h0004_0000);
    isqrt_op(3'd0, 3'd7, 3, 5, 32'h0000_8000);
    chk("isq_half", result_out, 32'h0000_8000);
    chk("isq_eq_kept", eq_out, 1);
    host_write(3'd1, 32'h0001_0000);
    back_to_back;
    exec_op(3'b000, 3'd3, 3'd1, 3'd2, 0, 3'd0, 1, 3'd3, 32'h1234_5678);
    chk("wb_wins", result_out, 32'h0012_4000);
    exec_op(3'b000, 3'd3, 3'd1, 3'd2, 1, 3'd1, 0, 3'd0, 32'h0005_0000);
    chk("old_src0", result_out, 32'h0012_4000);
    exec_op(3'b111, 3'd2, 3'd1, 3'd3, 0, 3'd0, 0, 3'd0, '0);
    chk("zero_op", result_out, 32'h0);
    wait_ready;
    instr_op_in = 3'b010;
    instr_dst_in = 3'd2;
    instr_src0_in = 3'd7;
    instr_valid_in = 1'b1;
    tick;
    instr_valid_in = 1'b0;
    isqrt_ready_in = 1'b1;
    tick;
    isqrt_ready_in = 1'b0;
    tick;
    rst_in = 1'b1;
    #1;
    chk("mid_rst_valid", isqrt_valid_out, 0);
    chk("mid_rst_done", done_out, 0);
    chk("mid_rst_ready", instr_ready_out, 0);
    chk("mid_rst_result", result_out, 0);
    chk("mid_rst_flags", {gt_out, eq_out, lt_out}, 0);
    for (int i = 0; i < N; i++) begin
      m[i] = '0;
      check_reg("mid_rst_reg", 3'(i));
    end
    {mgt, meq, mlt} = 3'b000;
    n_done = 0;
    stall_exp = 0;
    tick;
    tick;
    rst_in = 1'b0;
    chk("mid_rel_ready_low", instr_ready_out, 0);
    chk("mid_rel_cnt", instr_count_out, 0);
    chk("mid_rel_stall", stall_count_out, 0);
    tick;
    chk("mid_rel_ready_high", instr_ready_out, 1);
    chk("mid_rel_done", done_out, 0);
    repeat (60) begin
      logic [2:0] op;
      op = 3'($urandom_range(7));
      if ($urandom_range(2) == 0) host_write(3'($urandom_range(7)), $urandom);
      if (op == 3'b010)
        isqrt_op(3'($urandom_range(7)), 3'($urandom_range(7)), $urandom_range(3), $urandom_range(3), $urandom);
      else
        exec_op(op, 3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)),
                $urandom_range(3) == 0, 3'($urandom_range(7)), $urandom_range(3) == 0, 3'($urandom_range(7)), $urandom);
    end
    tick;
    tick;
    for (int i = 0; i < N; i++) check_reg("final_reg", 3'(i));
`ifdef FP_SEQ_PERF_CNT_EN
    chk("instr_count", instr_count_out, n_done);
    chk("stall_count", stall_count_out, stall_exp);
`else
    chk("instr_count_tied", instr_count_out, 0);
    chk("stall_count_tied", stall_count_out, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fp_alu_sequencer.md
Name: fp_alu_sequencer

Overview:
- Issue-side controller for the combinational fixed-point ALU: accepts micro-instructions over a valid/ready stream, reads operands from a small register file, drives the ALU operand/select inputs, and writes back the result and flags.
- Opcode 3'b010 (inverse sqrt) is routed to the external isqrt unit over a request/response handshake.
- Sits between the ray-march control FSM and the ALU/isqrt datapath.

Parameters:
- NREGS, 8, number of `WIDTH-bit registers; power of two, ≥2.
- RA, $clog2(NREGS), register address width (derived, not overridden).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-high reset
- instr_valid_in  in  1  instruction offered
- instr_ready_out  out  1  sequencer can accept
- instr_op_in  in  3  ALU opcode (000 add, 001 mul, 010 isqrt, 011 max, 100 sub, 101 sign, 110 min, 111 zero)
- instr_dst_in / instr_src0_in / instr_src1_in  in  RA each  register indices
- wr_en_in, wr_addr_in[RA], wr_data_in[`WIDTH]  in  host register write
- rd_addr_in  in  RA ; rd_data_out  out  `WIDTH  host read, combinational
- alu_d1_out, alu_d0_out  out  `WIDTH signed  ALU operands (d1=A=reg[src0], d0=B=reg[src1])
- alu_sel_out  out  3  ALU select
- alu_res_in  in  `WIDTH ; alu_gt_in, alu_eq_in, alu_lt_in  in  1
- isqrt_valid_out  out  1 ; isqrt_ready_in  in  1 ; isqrt_d_out  out  `WIDTH
- isqrt_res_valid_in  in  1 ; isqrt_res_in  in  `WIDTH
- done_out  out  1  one-cycle completion pulse
- result_out  out  `WIDTH  last written-back value
- gt_out, eq_out, lt_out  out  1  sticky flags of last ALU op

Behaviour:
- Reset (async): state IDLE; all registers, operand latches, result_out, flags, done_out, isqrt_valid_out, alu_*_out := 0; instr_ready_out := 0 while rst_in is high, 1 in the first cycle after release.
- States: IDLE, EXEC, ISQ_REQ, ISQ_WAIT.
- IDLE: instr_ready_out=1. On valid&ready, latch op, dst, A=reg[src0], B=reg[src1]. Read-before-write: a host write in the same cycle is not seen. Next state is EXEC, or ISQ_REQ if op==010.
- EXEC (1 cycle): alu_d1_out=A, alu_d0_out=B, alu_sel_out=op, all registered. At the end of the cycle: reg[dst] := alu_res_in, result_out := alu_res_in, flags := alu_gt/eq/lt. done_out is high in the following cycle; state returns to IDLE. Op 111 writes 0.
- Latency: accept edge to done_out = 2 cycles. Throughput: 1 instruction per 2 cycles, so no hazards (reads occur after the previous writeback).
- ISQ_REQ: isqrt_valid_out=1, isqrt_d_out=A, held stable until isqrt_ready_in. On handshake, go to ISQ_WAIT with isqrt_valid_out=0 in the next cycle.
- ISQ_WAIT: on isqrt_res_valid_in, reg[dst] and result_out := isqrt_res_in; done_out pulses next cycle; IDLE. Flags unchanged. A res_valid arriving while ISQ_REQ is still pending is ignored.
- alu_sel_out is 0 outside EXEC.
- Host write: allowed in any state. If it collides with a writeback to the same address in the same cycle, the writeback wins.
- Register index 0 is an ordinary register.
- Reset mid-operation: abandons the instruction and drops isqrt_valid_out immediately; no done_out is produced.

Optional Feature:
- FP_SEQ_PERF_CNT_EN defined: adds 32-bit instr_count_out (completed instructions, increments on done_out) and 32-bit stall_count_out (cycles spent in ISQ_REQ/ISQ_WAIT). Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports remain and are tied to 0; no counter logic.

Test Plan:
- Host writes r1=1.5, r2=2.25; add r3=r1+r2 -> done_out 2 cycles after accept, r3=result_out=3.75, lt_out=1 (A<B), gt_out=0.
- mul r4=r1*r5 with r5=-2.0 -> r4=-3.0; then sub r6=r4-r4 -> 0.0 with eq_out=1.
- isqrt on r7=4.0, isqrt_ready_in delayed 3 cycles, response 0.5 after 5 more -> isqrt_d_out=4.0 held stable, r0=0.5, flags unchanged, instr_ready_out=0 throughout.
- Back-to-back valid held high: 4 instructions -> accepted on alternate cycles, each reads the previous result (chain r1=r1+r1 ×4 from 1.0 -> 16.0).
- Host write to dst in the writeback cycle of add -> ALU result retained. Host write in the accept cycle to src0 -> old value used.
- rst_in asserted during ISQ_WAIT -> isqrt_valid_out, done_out=0, all registers 0, instr_ready_out=1 one cycle after release. With FP_SEQ_PERF_CNT_EN, counters read 0.
